// File: rtl/data_mem_param.sv
`default_nettype none
// ==========================================================================
// data_mem_param : DEPTH x DATA_W operand memory, 2 sync reads, 1 write,
//                  hardware clear sequencer. Rev 1.0
// ==========================================================================
module data_mem_param #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int BYPASS     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              write,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] read_address1,
  input  logic [ADDR_W-1:0] read_address2,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic              rd_valid,
  output logic              ready
);

  localparam logic [0:0]        S_CLEAR = 1'b0;
  localparam logic [0:0]        S_RUN   = 1'b1;
  localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] out_data1_q, out_data1_d;
  logic [DATA_W-1:0] out_data2_q, out_data2_d;
  logic              rd_valid_q, rd_valid_d;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr_ok, w_rd1_ok, w_rd2_ok;
  logic              w_hit1, w_hit2;

  // Addresses at or beyond DEPTH only exist for non-power-of-2 depths
  assign w_wr_ok  = {1'b0, write_address} < c_depth;
  assign w_rd1_ok = {1'b0, read_address1} < c_depth;
  assign w_rd2_ok = {1'b0, read_address2} < c_depth;

  if (BYPASS != 0) begin : g_bypass
    assign w_hit1 = write && (write_address == read_address1);
    assign w_hit2 = write && (write_address == read_address2);
  end else begin : g_no_bypass
    assign w_hit1 = 1'b0;
    assign w_hit2 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR) begin
      if ((CLR_ON_RST == 0) || (clr_ptr_q == c_last)) begin
        state_d = S_RUN;
      end
    end
  end

  always_comb begin
    ready = (state_q == S_RUN);
  end

  always_comb begin
    clr_ptr_d   = clr_ptr_q;
    out_data1_d = out_data1_q;
    out_data2_d = out_data2_q;
    rd_valid_d  = 1'b0;
    w_we        = 1'b0;
    w_waddr     = write_address;
    w_wdata     = in_data;
    if (state_q == S_CLEAR) begin
      if (CLR_ON_RST != 0) begin
        w_we      = 1'b1;
        w_waddr   = clr_ptr_q;
        w_wdata   = '0;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      end
    end else if (enable) begin
      rd_valid_d  = 1'b1;
      out_data1_d = !w_rd1_ok ? '0 : (w_hit1 ? in_data : mem[read_address1]);
      out_data2_d = !w_rd2_ok ? '0 : (w_hit2 ? in_data : mem[read_address2]);
      w_we        = write && w_wr_ok;
    end
  end

  // The array itself has no reset; zero-fill is done by the clear sequencer
  always_ff @(posedge clk) begin
    if (!rst && w_we) begin
      mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr_q   <= '0;
      out_data1_q <= '0;
      out_data2_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      clr_ptr_q   <= clr_ptr_d;
      out_data1_q <= out_data1_d;
      out_data2_q <= out_data2_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign out_data1 = out_data1_q;
  assign out_data2 = out_data2_q;
  assign rd_valid  = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_param.sv
`default_nettype none
// ==========================================================================
// tb_data_mem_param : default instance plus a DEPTH=48 / no-bypass /
//                     keep-on-reset instance, driven with shared stimulus. Rev 1.0
// ==========================================================================
module tb_data_mem_param;
  logic       clk = 1'b0;
  logic       rst, enable, write;
  logic [5:0] wa, ra1, ra2;
  logic [7:0] din;

  logic [7:0] a_o1, a_o2, b_o1, b_o2;
  logic       a_v, a_r, b_v, b_r;

  int n_checks = 0;
  int n_errors = 0;

  int p_depth [2] = '{64, 48};
  bit p_byp   [2] = '{1'b1, 1'b0};
  bit p_clr   [2] = '{1'b1, 1'b0};

  logic [7:0] m_mem   [2][64];
  bit         m_known [2][64];
  logic [7:0] m_o1 [2], m_o2 [2];
  bit         m_k1 [2], m_k2 [2], m_v [2], m_rdy [2];
  int         m_cnt [2];
  bit         model_on = 1'b0;

  always #5 clk = ~clk;

  data_mem_param dut_a (
    .clk(clk), .rst(rst), .enable(enable), .write(write),
    .write_address(wa), .in_data(din), .read_address1(ra1), .read_address2(ra2),
    .out_data1(a_o1), .out_data2(a_o2), .rd_valid(a_v), .ready(a_r)
  );

  data_mem_param #(.DATA_W(8), .ADDR_W(6), .DEPTH(48), .BYPASS(0), .CLR_ON_RST(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .write(write),
    .write_address(wa), .in_data(din), .read_address1(ra1), .read_address2(ra2),
    .out_data1(b_o1), .out_data2(b_o2), .rd_valid(b_v), .ready(b_r)
  );

  task automatic read_model(input int i, input logic [5:0] a, output logic [7:0] d, output bit k);
    if (int'(a) >= p_depth[i]) begin
      d = 8'h00; k = 1'b1;
    end else if (p_byp[i] && write && wa == a) begin
      d = din; k = 1'b1;
    end else begin
      d = m_mem[i][a]; k = m_known[i][a];
    end
  endtask

  // Reset-to-ready is a simple cycle count; a clearing reset is seen as an instant zero-fill
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int need;
      need = p_clr[i] ? p_depth[i] : 1;
      if (rst) begin
        m_cnt[i] = 0; m_rdy[i] = 1'b0; m_v[i] = 1'b0;
        m_o1[i] = 8'h00; m_o2[i] = 8'h00; m_k1[i] = 1'b1; m_k2[i] = 1'b1;
        if (p_clr[i]) begin
          for (int a = 0; a < 64; a++) begin
            m_mem[i][a] = 8'h00; m_known[i][a] = 1'b1;
          end
        end
      end else if (!m_rdy[i]) begin
        m_cnt[i]++;
        m_v[i] = 1'b0;
        if (m_cnt[i] >= need) m_rdy[i] = 1'b1;
      end else if (enable) begin
        read_model(i, ra1, m_o1[i], m_k1[i]);
        read_model(i, ra2, m_o2[i], m_k2[i]);
        if (write && int'(wa) < p_depth[i]) begin
          m_mem[i][wa] = din; m_known[i][wa] = 1'b1;
        end
        m_v[i] = 1'b1;
      end else begin
        m_v[i] = 1'b0;
      end
    end
  endtask

  task automatic cmp_bit(input int i, input string name, input logic act, input bit exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] @%0t: got %b expected %b", name, i, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [7:0] o1, input logic [7:0] o2,
                          input logic v, input logic r);
    cmp_bit(i, "ready", r, m_rdy[i]);
    cmp_bit(i, "rd_valid", v, m_v[i]);
    if (m_k1[i]) begin
      n_checks++;
      if (o1 !== m_o1[i]) begin
        n_errors++;
        $display("FAIL out_data1[%0d] @%0t: got %h expected %h", i, $time, o1, m_o1[i]);
      end
    end
    if (m_k2[i]) begin
      n_checks++;
      if (o2 !== m_o2[i]) begin
        n_errors++;
        $display("FAIL out_data2[%0d] @%0t: got %h expected %h", i, $time, o2, m_o2[i]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      cmp_inst(0, a_o1, a_o2, a_v, a_r);
      cmp_inst(1, b_o1, b_o2, b_v, b_r);
    end
  end

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic acc(input bit en, input bit we, input logic [5:0] a, input logic [7:0] d,
                     input logic [5:0] r1, input logic [5:0] r2);
    enable = en; write = we; wa = a; din = d; ra1 = r1; ra2 = r2;
    step();
  endtask

  task automatic wait_ready_a(output int cyc);
    cyc = 0;
    while (a_r !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 64; a++) m_known[i][a] = 1'b0;
    rst = 1'b1; enable = 1'b0; write = 1'b0; wa = '0; ra1 = '0; ra2 = '0; din = '0;
    step();
    model_on = 1'b1;
    rst = 1'b0;
    lit("reset_ready", {7'd0, a_r}, 8'h00);
    lit("reset_out1", a_o1, 8'h00);

    // Clear takes exactly DEPTH cycles; every word reads back as zero
    wait_ready_a(cyc);
    lit("clear_cycles", 8'(cyc), 8'd64);
    for (int a = 0; a < 64; a++) begin
      acc(1, 0, 0, 0, 6'(a), 6'(63 - a));
      lit("clear_zero", a_o1, 8'h00);
    end

    acc(1, 1, 0, 8'h31, 0, 0);
    acc(1, 1, 1, 8'h23, 0, 0);
    acc(1, 0, 0, 0, 0, 1);
    lit("rd_a_o1", a_o1, 8'h31);
    lit("rd_a_o2", a_o2, 8'h23);
    lit("rd_a_v", {7'd0, a_v}, 8'h01);
    lit("rd_b_o1", b_o1, 8'h31);

    // Same-address read during write: bypass on dut_a, old word on dut_b
    acc(1, 1, 5, 8'h00, 0, 0);
    acc(1, 1, 5, 8'h9C, 5, 5);
    lit("byp_a_o1", a_o1, 8'h9C);
    lit("byp_a_o2", a_o2, 8'h9C);
    lit("nobyp_b_o1", b_o1, 8'h00);
    lit("nobyp_b_o2", b_o2, 8'h00);
    acc(1, 0, 0, 0, 5, 5);
    lit("reread_b_o1", b_o1, 8'h9C);

    acc(1, 0, 0, 0, 0, 1);
    acc(0, 1, 7, 8'hFF, 7, 7);
    lit("dis_hold_o1", a_o1, 8'h31);
    lit("dis_v", {7'd0, a_v}, 8'h00);
    acc(1, 0, 0, 0, 7, 7);
    lit("dis_nowrite", a_o1, 8'h00);

    acc(1, 1, 10, 8'h6A, 0, 0);
    acc(1, 1, 50, 8'h55, 50, 0);
    acc(1, 0, 0, 0, 50, 10);
    lit("oor_b_o1", b_o1, 8'h00);
    lit("oor_b_v", {7'd0, b_v}, 8'h01);
    lit("inrange_a_o1", a_o1, 8'h55);
    lit("keep_b_o2", b_o2, 8'h6A);

    // Reset again 20 cycles into a clear, with writes attempted meanwhile
    rst = 1'b1; acc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 19; k++) acc(1, 1, 3, 8'hAA, 3, 3);
    rst = 1'b1; acc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    lit("reclr_ready", {7'd0, a_r}, 8'h00);
    wait_ready_a(cyc);
    lit("reclr_cycles", 8'(cyc), 8'd64);
    acc(1, 0, 0, 0, 3, 10);
    lit("reclr_a_o1", a_o1, 8'h00);
    lit("reclr_a_o2", a_o2, 8'h00);
    lit("run_b_o1", b_o1, 8'hAA);
    lit("survive_b_o2", b_o2, 8'h6A);

    for (int k = 0; k < 3000; k++) begin
      logic [5:0] a, r1, r2;
      a  = 6'($urandom_range(0, 63));
      r1 = ($urandom_range(0, 3) == 0) ? a : 6'($urandom_range(0, 63));
      r2 = ($urandom_range(0, 3) == 0) ? a : 6'($urandom_range(0, 63));
      rst = ($urandom_range(0, 299) == 0);
      acc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, 8'($urandom), r1, r2);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end, expected to finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
